// File: rtl/prod_accum.sv
// prod_accum -- frame accumulator for unsigned 8-bit products.
//
// Sums LEN accepted products into an ACC_W-bit accumulator (modulo 2^ACC_W).
// It also keeps a sticky flag that records any carry out of the top bit.
// After the LEN-th product, the sum and flag are presented on acc_out/ovf
// with out_valid. They are held there until the downstream stage takes them.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   clr        in   synchronous frame abort, overrides every other event
//   in_valid   in   a product is present on prod
//   prod       in   8-bit unsigned product
//   in_ready   out  product accepted this cycle (registered state only)
//   out_valid  out  acc_out/ovf hold a completed frame
//   out_ready  in   downstream accepts the result
//   acc_out    out  frame sum, ACC_W bits
//   ovf        out  a carry out of ACC_W occurred during the frame
module prod_accum #(
   parameter int LEN   = 4,
   parameter int ACC_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [7:0]       prod,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf
);

   localparam int CNT_W = $clog2(LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t             state_q,     state_d;
   logic [CNT_W-1:0]   count_q,     count_d;
   logic [ACC_W-1:0]   acc_q,       acc_d;
   logic               sticky_q,    sticky_d;
   logic [ACC_W-1:0]   acc_out_q,   acc_out_d;
   logic               ovf_q,       ovf_d;
   logic               out_valid_q, out_valid_d;

   logic               xfer;
   logic               consume;
   logic               last;
   logic [ACC_W:0]     sum;
   logic               sticky_new;

   // Zero-extended add that keeps the carry in the extra top bit.
   function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] a,
                                              input logic [7:0]       b);
      return {1'b0, a} + {{(ACC_W - 7){1'b0}}, b};
   endfunction

   assign xfer       = in_valid && (state_q == ST_ACC);
   assign consume    = out_valid_q && out_ready;
   assign last       = (count_q == LAST_CNT);
   assign sum        = add_ext(acc_q, prod);
   assign sticky_new = sticky_q | sum[ACC_W];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_ACC;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = ST_ACC;
      end else begin
         case (state_q)
            ST_ACC:  if (xfer && last) state_d = ST_HOLD;
            ST_HOLD: if (consume)      state_d = ST_ACC;
            default: state_d = ST_ACC;
         endcase
      end
   end

   // Outputs decoded from registered state; in_ready never sees out_ready.
   always_comb begin
      in_ready  = (state_q == ST_ACC);
      out_valid = out_valid_q;
      acc_out   = acc_out_q;
      ovf       = ovf_q;
   end

   // Datapath next-state. xfer (ACC) and consume (HOLD) are exclusive.
   always_comb begin
      count_d     = count_q;
      acc_d       = acc_q;
      sticky_d    = sticky_q;
      acc_out_d   = acc_out_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      if (clr) begin
         count_d     = '0;
         acc_d       = '0;
         sticky_d    = 1'b0;
         acc_out_d   = '0;
         ovf_d       = 1'b0;
         out_valid_d = 1'b0;
      end else if (consume) begin
         count_d     = '0;
         acc_d       = '0;
         sticky_d    = 1'b0;
         out_valid_d = 1'b0;
      end else if (xfer) begin
         acc_d    = sum[ACC_W-1:0];
         sticky_d = sticky_new;
         // In HOLD, count may reach LEN; it is cleared on consume.
         count_d  = count_q + CNT_W'(1);
         if (last) begin
            acc_out_d   = sum[ACC_W-1:0];
            ovf_d       = sticky_new;
            out_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         acc_q       <= '0;
         sticky_q    <= 1'b0;
         acc_out_q   <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         acc_q       <= acc_d;
         sticky_q    <= sticky_d;
         acc_out_q   <= acc_out_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_prod_accum.sv
// Testbench for prod_accum.
// Instance u0 uses the default parameters (LEN=4, ACC_W=12).
// Instance u1 uses LEN=2, ACC_W=8 to exercise the overflow path.
// Expected results are queued by the stimulus and popped by per-instance
// monitors whenever a result handshake is seen.
module tb_prod_accum;

   typedef struct packed {
      logic [31:0] acc;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst0, clr0, in_valid0, in_ready0, out_valid0, out_ready0, ovf0;
   logic [7:0]  prod0;
   logic [11:0] acc_out0;
   logic        rst1, clr1, in_valid1, in_ready1, out_valid1, out_ready1, ovf1;
   logic [7:0]  prod1;
   logic [7:0]  acc_out1;

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   prod_accum u0 (
      .clk(clk), .rst(rst0), .clr(clr0), .in_valid(in_valid0), .prod(prod0),
      .in_ready(in_ready0), .out_valid(out_valid0), .out_ready(out_ready0),
      .acc_out(acc_out0), .ovf(ovf0)
   );

   prod_accum #(.LEN(2), .ACC_W(8)) u1 (
      .clk(clk), .rst(rst1), .clr(clr1), .in_valid(in_valid1), .prod(prod1),
      .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready1),
      .acc_out(acc_out1), .ovf(ovf1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Result monitors: one pop per handshake (consumed at the following edge).
   always @(negedge clk) begin
      if (out_valid0 === 1'b1 && out_ready0 === 1'b1) begin
         if (q0.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL u0 unexpected result: got acc_out=%0d, expected no result", acc_out0);
         end else begin
            e0 = q0.pop_front();
            chk("u0 acc_out", 32'(acc_out0), e0.acc);
            chk("u0 ovf", 32'(ovf0), 32'(e0.ovf));
         end
      end
   end

   always @(negedge clk) begin
      if (out_valid1 === 1'b1 && out_ready1 === 1'b1) begin
         if (q1.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL u1 unexpected result: got acc_out=%0d, expected no result", acc_out1);
         end else begin
            e1 = q1.pop_front();
            chk("u1 acc_out", 32'(acc_out1), e1.acc);
            chk("u1 ovf", 32'(ovf1), 32'(e1.ovf));
         end
      end
   end

   task automatic send0(input logic [7:0] p);
      in_valid0 = 1'b1;
      prod0     = p;
      @(posedge clk); #1;
   endtask

   task automatic send1(input logic [7:0] p);
      in_valid1 = 1'b1;
      prod1     = p;
      @(posedge clk); #1;
   endtask

   task automatic wait_out0(input string nm);
      int n = 0;
      while (out_valid0 !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk(nm, 32'(out_valid0), 32'd1);
   endtask

   task automatic wait_out1(input string nm);
      int n = 0;
      while (out_valid1 !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk(nm, 32'(out_valid1), 32'd1);
   endtask

   initial begin
      rst0 = 1'b0; clr0 = 1'b0; in_valid0 = 1'b0; prod0 = '0; out_ready0 = 1'b1;
      rst1 = 1'b0; clr1 = 1'b0; in_valid1 = 1'b0; prod1 = '0; out_ready1 = 1'b1;
      #1;
      rst0 = 1'b1;
      rst1 = 1'b1;
      #1;
      // Reset values before any clock edge
      chk("reset out_valid", 32'(out_valid0), 32'd0);
      chk("reset acc_out", 32'(acc_out0), 32'd0);
      chk("reset ovf", 32'(ovf0), 32'd0);
      chk("reset in_ready", 32'(in_ready0), 32'd1);
      @(posedge clk); #1;
      rst0 = 1'b0;
      rst1 = 1'b0;

      // 4 x 225 back to back, result valid one cycle, held one cycle
      q0.push_back('{acc: 32'd900, ovf: 1'b0});
      for (int i = 0; i < 4; i++) send0(8'd225);
      in_valid0 = 1'b0;
      chk("latency out_valid", 32'(out_valid0), 32'd1);
      @(posedge clk); #1;
      chk("out_valid one cycle", 32'(out_valid0), 32'd0);

      // 1..4 with two-cycle gaps
      q0.push_back('{acc: 32'd10, ovf: 1'b0});
      for (int i = 1; i <= 4; i++) begin
         send0(8'(i));
         in_valid0 = 1'b0;
         if (i < 4) begin
            for (int g = 0; g < 2; g++) begin
               chk("gap in_ready", 32'(in_ready0), 32'd1);
               @(posedge clk); #1;
            end
         end
      end
      wait_out0("gap frame valid");
      @(posedge clk); #1;

      // Hold with back-pressure; then consume with in_valid already high
      q0.push_back('{acc: 32'd100, ovf: 1'b0});
      q0.push_back('{acc: 32'd10, ovf: 1'b0});
      out_ready0 = 1'b0;
      for (int i = 0; i < 4; i++) send0(8'd25);
      in_valid0 = 1'b1;
      prod0     = 8'd50;
      for (int i = 0; i < 3; i++) begin
         chk("hold out_valid", 32'(out_valid0), 32'd1);
         chk("hold acc_out", 32'(acc_out0), 32'd100);
         chk("hold in_ready", 32'(in_ready0), 32'd0);
         @(posedge clk); #1;
      end
      out_ready0 = 1'b1;
      prod0      = 8'd7;
      @(posedge clk); #1;
      chk("post-consume in_ready", 32'(in_ready0), 32'd1);
      chk("post-consume out_valid", 32'(out_valid0), 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) send0(8'd1);
      in_valid0 = 1'b0;
      wait_out0("7+1+1+1 valid");
      @(posedge clk); #1;

      // clr after two products, with a product offered in the clr cycle
      q0.push_back('{acc: 32'd20, ovf: 1'b0});
      send0(8'd3);
      send0(8'd3);
      clr0  = 1'b1;
      prod0 = 8'd9;
      @(posedge clk); #1;
      clr0      = 1'b0;
      in_valid0 = 1'b0;
      chk("clr in_ready", 32'(in_ready0), 32'd1);
      chk("clr out_valid", 32'(out_valid0), 32'd0);
      for (int i = 0; i < 4; i++) send0(8'd5);
      in_valid0 = 1'b0;
      wait_out0("after clr valid");
      @(posedge clk); #1;

      // Asynchronous reset during HOLD
      out_ready0 = 1'b0;
      for (int i = 0; i < 4; i++) send0(8'd50);
      in_valid0 = 1'b0;
      wait_out0("pre-reset hold");
      #2 rst0 = 1'b1;
      #1;
      chk("async rst out_valid", 32'(out_valid0), 32'd0);
      chk("async rst acc_out", 32'(acc_out0), 32'd0);
      chk("async rst in_ready", 32'(in_ready0), 32'd1);
      #2 rst0 = 1'b0;
      out_ready0 = 1'b1;
      q0.push_back('{acc: 32'd40, ovf: 1'b0});
      for (int i = 0; i < 4; i++) send0(8'd10);
      in_valid0 = 1'b0;
      wait_out0("post-reset frame valid");
      @(posedge clk); #1;

      // Narrow instance: wrap and sticky overflow
      q1.push_back('{acc: 32'd44, ovf: 1'b1});
      q1.push_back('{acc: 32'd30, ovf: 1'b0});
      q1.push_back('{acc: 32'd254, ovf: 1'b1});
      q1.push_back('{acc: 32'd0, ovf: 1'b0});
      send1(8'd200); send1(8'd100);
      in_valid1 = 1'b0;
      wait_out1("u1 200+100 valid");
      @(posedge clk); #1;
      send1(8'd10); send1(8'd20);
      in_valid1 = 1'b0;
      wait_out1("u1 10+20 valid");
      @(posedge clk); #1;
      send1(8'd255); send1(8'd255);
      in_valid1 = 1'b0;
      wait_out1("u1 255+255 valid");
      @(posedge clk); #1;
      send1(8'd0); send1(8'd0);
      in_valid1 = 1'b0;
      wait_out1("u1 0+0 valid");
      @(posedge clk); #1;

      repeat (3) @(posedge clk);
      #1;
      chk("u0 results outstanding", 32'(q0.size()), 32'd0);
      chk("u1 results outstanding", 32'(q1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
